// File: rtl/trace_pkg.sv
// Shared types and constants for the execution trace buffer.
// Record layout, flag bit positions and the drop counter ceiling.
package trace_pkg;

  localparam int FLAG_REGWEN = 0;
  localparam int FLAG_MEMRW  = 1;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Widest cycle stamp a record can carry; TS_W must not exceed it.
  localparam int TS_MAX_W = 32;
  // pc + inst + wdata + flags, i.e. everything except the stamp.
  localparam int REC_HDR_W = 98;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         inst;
    logic [31:0]         wdata;
    logic [1:0]          flags;
    logic [TS_MAX_W-1:0] ts;
  } trace_rec_t;

endpackage

// File: rtl/exec_trace_buffer_if.sv
// Host-side drain port of the trace buffer: valid/ready plus head record.
// master = trace buffer (drives record), slave = host (drives ready).
interface exec_trace_buffer_if #(
  parameter int TS_W = 16
);
  logic            o_valid;
  logic            i_ready;
  logic [31:0]     o_rec_pc;
  logic [31:0]     o_rec_inst;
  logic [31:0]     o_rec_wdata;
  logic [1:0]      o_rec_flags;
  logic [TS_W-1:0] o_rec_ts;

  modport master (
    output o_valid, o_rec_pc, o_rec_inst,
    output o_rec_wdata, o_rec_flags, o_rec_ts,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_rec_pc, o_rec_inst,
    input  o_rec_wdata, o_rec_flags, o_rec_ts,
    output i_ready
  );
endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Ports: push/wdata, pop/rdata (0 when empty), full, empty, count.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  // A pop in the same edge frees the slot, so push is allowed when full.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Storage is never reset; mask it so X cannot leak while empty.
  assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/exec_trace_buffer.sv
// Per-cycle execution trace capture with cycle stamp and overflow count.
// Ports: core debug inputs, drain interface, occupancy and drop status.
module exec_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [31:0]            i_pc,
  input  logic [31:0]            i_inst,
  input  logic [31:0]            i_writeBack,
  input  logic                   i_RegWEn,
  input  logic                   i_memRW,
  input  logic                   i_clear_ovf,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic [15:0]            o_dropped,
  exec_trace_buffer_if.master    bus
);
  localparam int W = REC_HDR_W + TS_W;

  logic [TS_W-1:0] ts_q;
  trace_rec_t      rec_in;
  trace_rec_t      head;
  logic [W-1:0]    fifo_wdata;
  logic [W-1:0]    fifo_rdata;
  logic            full;
  logic            empty;
  logic            pop;
  logic            drop;

  always_comb begin
    rec_in                    = '0;
    rec_in.pc                 = i_pc;
    rec_in.inst               = i_inst;
    rec_in.wdata              = i_writeBack;
    rec_in.flags[FLAG_REGWEN] = i_RegWEn;
    rec_in.flags[FLAG_MEMRW]  = i_memRW;
    rec_in.ts                 = TS_MAX_W'(ts_q);
  end

  assign fifo_wdata = {rec_in.pc, rec_in.inst, rec_in.wdata,
                       rec_in.flags, TS_W'(rec_in.ts)};

  always_comb begin
    head       = '0;
    head.pc    = fifo_rdata[W-1 -: 32];
    head.inst  = fifo_rdata[W-33 -: 32];
    head.wdata = fifo_rdata[W-65 -: 32];
    head.flags = fifo_rdata[TS_W +: 2];
    head.ts    = TS_MAX_W'(fifo_rdata[TS_W-1:0]);
  end

  assign pop  = bus.i_ready & ~empty;
  // Full never coincides with empty, so a ready host always frees a slot.
  assign drop = i_enable & full & ~bus.i_ready;

  trace_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (i_enable),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (o_count)
  );

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  // A drop in the same edge as a clear wins and restarts the count at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow <= 1'b0;
      o_dropped  <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (i_clear_ovf)              o_dropped <= 16'd1;
      else if (o_dropped != DROP_MAX) o_dropped <= o_dropped + 16'd1;
    end else if (i_clear_ovf) begin
      o_overflow <= 1'b0;
      o_dropped  <= '0;
    end
  end

  assign bus.o_valid     = ~empty;
  assign bus.o_rec_pc    = head.pc;
  assign bus.o_rec_inst  = head.inst;
  assign bus.o_rec_wdata = head.wdata;
  assign bus.o_rec_flags = head.flags;
  assign bus.o_rec_ts    = TS_W'(head.ts);

endmodule
